// File: rtl/muldiv_sched.sv
// Multi-cycle multiply/divide unit with its HI/LO register pair and the
// stall generator that keeps D-stage HI/LO instructions away from an
// in-flight operation. The result is computed when the operation is
// accepted, parked in staging registers, and committed to HI/LO on the
// last busy cycle. This gives a fixed, op-dependent latency.
module muldiv_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        mt_we,
    input  logic        mt_sel,
    input  logic        md_use_D,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [31:0]     hi_q;
    logic [31:0]     lo_q;
    logic [31:0]     hi_n_q;
    logic [31:0]     lo_n_q;
    logic [31:0]     hi_n_d;
    logic [31:0]     lo_n_d;

    // op[0] = 0 selects the signed flavour of both mult and div
    logic            is_signed;
    logic [63:0]     mul_a;
    logic [63:0]     mul_b;
    logic [63:0]     prod;
    logic [31:0]     div_b_safe;
    logic [31:0]     dvd_mag;
    logic [31:0]     dvs_mag;
    logic [31:0]     quo_mag;
    logic [31:0]     rem_mag;
    logic [31:0]     quo;
    logic [31:0]     rem;

    assign is_signed = ~op[0];

    // Sign- or zero-extend to 64 bits; the low 64 bits of the product are
    // then correct for both signed and unsigned operands.
    assign mul_a = {{32{is_signed & src_a[31]}}, src_a};
    assign mul_b = {{32{is_signed & src_b[31]}}, src_b};
    assign prod  = mul_a * mul_b;

    // Signed divide runs on magnitudes so 0x80000000 / -1 falls out as
    // quotient 0x80000000, remainder 0. The zero divisor is replaced by 1
    // only to keep the divider well defined; its result is discarded.
    assign div_b_safe = (src_b == 32'd0) ? 32'd1 : src_b;
    assign dvd_mag    = (is_signed & src_a[31]) ? (32'd0 - src_a) : src_a;
    assign dvs_mag    = (is_signed & div_b_safe[31]) ? (32'd0 - div_b_safe) : div_b_safe;
    assign quo_mag    = dvd_mag / dvs_mag;
    assign rem_mag    = dvd_mag % dvs_mag;
    assign quo        = (is_signed & (src_a[31] ^ src_b[31])) ? (32'd0 - quo_mag) : quo_mag;
    assign rem        = (is_signed & src_a[31]) ? (32'd0 - rem_mag) : rem_mag;

    // Staging value for the operation presented this cycle; divide by zero keeps HI/LO
    always_comb begin
        hi_n_d = hi_q;
        lo_n_d = lo_q;
        if (!op[1]) begin
            hi_n_d = prod[63:32];
            lo_n_d = prod[31:0];
        end else if (src_b != 32'd0) begin
            hi_n_d = rem;
            lo_n_d = quo;
        end
    end

    // Sequencer: accept an op or an mt write in IDLE, count down in RUN, commit at the end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            hi_n_q  <= 32'd0;
            lo_n_q  <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        hi_n_q  <= hi_n_d;
                        lo_n_q  <= lo_n_d;
                        cnt_q   <= op[1] ? DIV_LOAD : MULT_LOAD;
                        state_q <= RUN;
                    end else if (mt_we) begin
                        if (mt_sel) begin
                            lo_q <= src_a;
                        end else begin
                            hi_q <= src_a;
                        end
                    end
                end
                RUN: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        hi_q    <= hi_n_q;
                        lo_q    <= lo_n_q;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy  = (state_q == RUN);
    assign done  = busy & (cnt_q == '0);
    assign stall = md_use_D & (start | busy);
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_muldiv_sched.sv
// Self-checking bench for muldiv_sched. Inputs are driven 1 ns after the
// rising edge, outputs sampled on the falling edge. Expected HI/LO come from
// 64-bit integer arithmetic on a model of the register pair.
module tb_muldiv_sched;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic        mt_we = 1'b0;
    logic        mt_sel = 1'b0;
    logic        md_use_D = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall;

    int tests = 0;
    int failed = 0;
    int viol = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    muldiv_sched #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .src_a   (src_a),
        .src_b   (src_b),
        .mt_we   (mt_we),
        .mt_sel  (mt_sel),
        .md_use_D(md_use_D),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo),
        .stall   (stall)
    );

    always #5 clk = ~clk;

    // Protocol monitor: a start or mt write while busy is a pipeline violation
    always @(negedge clk) begin
        if (busy === 1'b1 && (start === 1'b1 || mt_we === 1'b1)) viol++;
    end

    // Reference arithmetic; upd = 0 means HI/LO keep their values
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el, output bit upd);
        longint          sx, sy, sp, sq, sr;
        longint unsigned ux, uy, up, uq, ur;
        upd = 1'b1;
        eh  = 32'd0;
        el  = 32'd0;
        case (o)
            2'b00: begin
                sx = longint'($signed(a));
                sy = longint'($signed(b));
                sp = sx * sy;
                eh = sp[63:32];
                el = sp[31:0];
            end
            2'b01: begin
                ux = longint'(a);
                uy = longint'(b);
                up = ux * uy;
                eh = up[63:32];
                el = up[31:0];
            end
            2'b10: begin
                if (b == 32'd0) begin
                    upd = 1'b0;
                end else begin
                    sx = longint'($signed(a));
                    sy = longint'($signed(b));
                    sq = sx / sy;
                    sr = sx % sy;
                    eh = sr[31:0];
                    el = sq[31:0];
                end
            end
            default: begin
                if (b == 32'd0) begin
                    upd = 1'b0;
                end else begin
                    ux = longint'(a);
                    uy = longint'(b);
                    uq = ux / uy;
                    ur = ux % uy;
                    eh = ur[31:0];
                    el = uq[31:0];
                end
            end
        endcase
    endfunction

    // One complete operation from start to the idle cycle after done
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit use_d, input bit mt_at_start, input bit mt_in_run);
        logic [31:0] eh, el, old_h, old_l;
        bit upd, ended;
        int n, busy_cnt, done_cnt, done_at, stall_cnt, early, viol0;
        model(o, a, b, eh, el, upd);
        if (!upd) begin
            eh = m_hi;
            el = m_lo;
        end
        n = o[1] ? DIV_N : MULT_N;
        old_h = m_hi;
        old_l = m_lo;
        viol0 = viol;
        busy_cnt = 0; done_cnt = 0; done_at = -1; stall_cnt = 0; early = 0; ended = 1'b0;

        start = 1'b1; op = o; src_a = a; src_b = b; md_use_D = use_d;
        mt_we = mt_at_start; mt_sel = 1'b0;
        #4;
        tests++;
        if (stall !== use_d || busy !== 1'b0) begin
            failed++;
            $display("FAIL start_cycle: stall=%b busy=%b expected stall=%b busy=0", stall, busy, use_d);
        end
        @(posedge clk); #1;
        start = 1'b0; mt_we = 1'b0; src_a = $urandom; src_b = $urandom;
        for (int k = 0; k < n + 4; k++) begin
            #4;
            if (busy !== 1'b1) begin
                ended = 1'b1;
                break;
            end
            busy_cnt++;
            if (stall === 1'b1) stall_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                done_at = busy_cnt;
            end
            if (hi !== old_h || lo !== old_l) early++;
            @(posedge clk); #1;
            mt_we = mt_in_run && (busy_cnt == 2);
            mt_sel = 1'b1;
            if (mt_we) src_a = ~old_l;
        end
        mt_we = 1'b0;

        tests++;
        if (!ended) begin failed++; $display("FAIL busy_timeout: busy still %b after %0d cycles", busy, n + 4); end
        tests++;
        if (busy_cnt != n) begin failed++; $display("FAIL busy_len: got %0d cycles expected %0d", busy_cnt, n); end
        tests++;
        if (done_cnt != 1 || done_at != n) begin
            failed++;
            $display("FAIL done_pulse: count=%0d at=%0d expected count=1 at=%0d", done_cnt, done_at, n);
        end
        tests++;
        if (stall_cnt != (use_d ? n : 0)) begin
            failed++;
            $display("FAIL stall_busy: got %0d stalled busy cycles expected %0d", stall_cnt, use_d ? n : 0);
        end
        tests++;
        if (stall !== 1'b0 || done !== 1'b0) begin
            failed++;
            $display("FAIL after_done: stall=%b done=%b expected 0/0", stall, done);
        end
        tests++;
        if (early != 0) begin failed++; $display("FAIL hilo_early: HI/LO changed in %0d busy cycles expected 0", early); end
        tests++;
        if (hi !== eh || lo !== el) begin
            failed++;
            $display("FAIL result op=%0d a=%h b=%h: hi=%h lo=%h expected hi=%h lo=%h", o, a, b, hi, lo, eh, el);
        end
        tests++;
        if ((viol - viol0) != (mt_in_run ? 1 : 0)) begin
            failed++;
            $display("FAIL protocol_flag: flagged %0d expected %0d", viol - viol0, mt_in_run ? 1 : 0);
        end
        m_hi = eh;
        m_lo = el;
        $display("[TB] op=%0d a=%h b=%h -> hi=%h lo=%h busy=%0d", o, a, b, hi, lo, busy_cnt);
        @(posedge clk); #1;
        md_use_D = 1'b0;
    endtask

    task automatic mt_write(input bit sel, input logic [31:0] d);
        mt_we = 1'b1; mt_sel = sel; src_a = d;
        #4;
        tests++;
        if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
            failed++;
            $display("FAIL mt_before: busy=%b hi=%h lo=%h expected 0 %h %h", busy, hi, lo, m_hi, m_lo);
        end
        @(posedge clk); #1;
        mt_we = 1'b0;
        if (sel) m_lo = d; else m_hi = d;
        #4;
        tests++;
        if (busy !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
            failed++;
            $display("FAIL mt_write sel=%b: busy=%b hi=%h lo=%h expected 0 %h %h", sel, busy, hi, lo, m_hi, m_lo);
        end
        $display("[TB] mt sel=%b data=%h -> hi=%h lo=%h", sel, d, hi, lo);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        md_use_D = 1'b1;
        #1;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || stall !== 1'b0) begin
            failed++;
            $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h stall=%b expected all 0", busy, done, hi, lo, stall);
        end
        #2 reset = 1'b0;
        md_use_D = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_idle_stall();
        md_use_D = 1'b1;
        #4;
        tests++;
        if (stall !== 1'b0) begin failed++; $display("FAIL idle_stall: stall=%b expected 0", stall); end
        @(posedge clk); #1;
        md_use_D = 1'b0;
    endtask

    task automatic test_mt();
        mt_write(1'b0, 32'hDEADBEEF);
        mt_write(1'b1, $urandom);
    endtask

    task automatic test_mult();
        do_op(2'b00, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) do_op(2'b00, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    endtask

    task automatic test_multu();
        do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) do_op(2'b01, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    endtask

    task automatic test_div();
        logic [31:0] b;
        do_op(2'b10, 32'hFFFFFFF9, 32'd2, 1'b1, 1'b0, 1'b0);
        do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            b = $urandom_range(1, 100);
            if ($urandom_range(0, 1) == 1) b = 32'd0 - b;
            if (i >= 4) b = $urandom | 32'd1;
            do_op(1'($urandom_range(0, 1)) ? 2'b11 : 2'b10, $urandom, b, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
    endtask

    task automatic test_div_zero();
        mt_write(1'b0, 32'h00000011);
        mt_write(1'b1, 32'h00000022);
        do_op(2'b11, 32'd7, 32'd0, 1'b1, 1'b0, 1'b0);
        do_op(2'b10, $urandom, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_op(2'b00, $urandom, $urandom, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) do_op(2'($urandom_range(0, 3)), $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    endtask

    task automatic test_mt_during_run();
        do_op(2'b00, $urandom, $urandom, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_op();
        int bad;
        bad = 0;
        start = 1'b1; op = 2'b00; src_a = $urandom | 32'h1; src_b = $urandom | 32'h1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #1 reset = 1'b1;
        #1;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            failed++;
            $display("FAIL reset_mid_op: busy=%b done=%b hi=%h lo=%h expected all 0", busy, done, hi, lo);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) bad++;
        end
        tests++;
        if (bad != 0) begin failed++; $display("FAIL late_write: %0d cycles with nonzero state after reset expected 0", bad); end
        m_hi = 32'd0;
        m_lo = 32'd0;
        $display("[TB] reset mid-op -> hi=%h lo=%h", hi, lo);
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_idle_stall();
        test_mt();
        test_mult();
        test_multu();
        test_div();
        test_div_zero();
        test_back_to_back();
        test_mt_during_run();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
